// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between ALU control and the execute ALU.
// The master drives the request side; the slave (the ALU) drives results.
interface alu_exec_unit_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
);
   logic                   start_i;
   logic [4:0]             alu_operation_i;
   logic [DATA_WIDTH-1:0]  a_data_i;
   logic [DATA_WIDTH-1:0]  b_data_i;
   logic [SHAMT_WIDTH-1:0] shamt_i;
   logic                   busy_o;
   logic                   done_o;
   logic [DATA_WIDTH-1:0]  alu_result_o;
   logic                   zero_o;
   logic                   branch_taken_o;
   logic                   illegal_op_o;

   modport master (
      output start_i, alu_operation_i, a_data_i, b_data_i, shamt_i,
      input  busy_o, done_o, alu_result_o, zero_o,
      input  branch_taken_o, illegal_op_o
   );

   modport slave (
      input  start_i, alu_operation_i, a_data_i, b_data_i, shamt_i,
      output busy_o, done_o, alu_result_o, zero_o,
      output branch_taken_o, illegal_op_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative
// one-bit-per-cycle SLL/SRL shifter, with start/done handshake.
module alu_exec_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic            clk,
   input  logic            reset,
   alu_exec_unit_if.slave  alu
);
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_OR   = 5'd2;
   localparam logic [4:0] OP_ORI  = 5'd3;
   localparam logic [4:0] OP_SRL  = 5'd4;
   localparam logic [4:0] OP_SLL  = 5'd5;
   localparam logic [4:0] OP_LUI  = 5'd6;
   localparam logic [4:0] OP_ANDI = 5'd7;
   localparam logic [4:0] OP_LW   = 5'd8;
   localparam logic [4:0] OP_SW   = 5'd9;
   localparam logic [4:0] OP_BEQ  = 5'd10;
   localparam logic [4:0] OP_BNE  = 5'd11;
   localparam logic [4:0] OP_NOR  = 5'd12;
   localparam logic [4:0] OP_AND  = 5'd13;
   localparam logic [4:0] OP_JMP  = 5'd14;
   localparam logic [4:0] OP_JAL  = 5'd15;
   localparam logic [4:0] OP_JR   = 5'd16;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic                   dir_left_q;
   logic [DATA_WIDTH-1:0]  work_q;
   logic [SHAMT_WIDTH-1:0] cnt_q;

   logic [DATA_WIDTH-1:0]  res_c;
   logic                   taken_c;
   logic                   illegal_c;
   logic                   is_shift_c;
   logic [DATA_WIDTH-1:0]  shifted_c;

   // Single-cycle result/flags from the live request operands
   always_comb begin
      res_c      = '0;
      taken_c    = 1'b0;
      illegal_c  = 1'b0;
      is_shift_c = 1'b0;
      case (alu.alu_operation_i)
         OP_ADD, OP_LW, OP_SW: res_c = alu.a_data_i + alu.b_data_i;
         OP_SUB:               res_c = alu.a_data_i - alu.b_data_i;
         OP_OR, OP_ORI:        res_c = alu.a_data_i | alu.b_data_i;
         OP_AND, OP_ANDI:      res_c = alu.a_data_i & alu.b_data_i;
         OP_NOR:               res_c = ~(alu.a_data_i | alu.b_data_i);
         OP_LUI:               res_c = {alu.b_data_i[15:0], 16'h0000};
         OP_JMP:               res_c = '0;
         OP_JAL, OP_JR:        res_c = alu.a_data_i;
         // shamt=0 shifts complete immediately with b unchanged
         OP_SRL, OP_SLL: begin
            res_c      = alu.b_data_i;
            is_shift_c = 1'b1;
         end
         OP_BEQ: begin
            res_c   = alu.a_data_i - alu.b_data_i;
            taken_c = (alu.a_data_i == alu.b_data_i);
         end
         OP_BNE: begin
            res_c   = alu.a_data_i - alu.b_data_i;
            taken_c = (alu.a_data_i != alu.b_data_i);
         end
         default: illegal_c = 1'b1;
      endcase
   end

   // One-bit step of the iterative shifter, zero fill
   always_comb begin
      shifted_c = dir_left_q ? (work_q << 1) : (work_q >> 1);
   end

   // Sequencer FSM with registered result, flags and handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         dir_left_q           <= 1'b0;
         work_q               <= '0;
         cnt_q                <= '0;
         alu.busy_o           <= 1'b0;
         alu.done_o           <= 1'b0;
         alu.alu_result_o     <= '0;
         alu.zero_o           <= 1'b0;
         alu.branch_taken_o   <= 1'b0;
         alu.illegal_op_o     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               alu.done_o <= 1'b0;
               if (alu.start_i) begin
                  alu.busy_o <= 1'b1;
                  dir_left_q <= (alu.alu_operation_i == OP_SLL);
                  if (is_shift_c && (alu.shamt_i != '0)) begin
                     work_q <= alu.b_data_i;
                     cnt_q  <= alu.shamt_i;
                     state  <= SHIFT;
                  end else begin
                     alu.alu_result_o   <= res_c;
                     alu.zero_o         <= (res_c == '0);
                     alu.branch_taken_o <= taken_c;
                     alu.illegal_op_o   <= illegal_c;
                     alu.done_o         <= 1'b1;
                     state              <= DONE;
                  end
               end
            end
            SHIFT: begin
               work_q <= shifted_c;
               cnt_q  <= cnt_q - 1'b1;
               if (cnt_q == SHAMT_WIDTH'(1)) begin
                  alu.alu_result_o   <= shifted_c;
                  alu.zero_o         <= (shifted_c == '0);
                  alu.branch_taken_o <= 1'b0;
                  alu.illegal_op_o   <= 1'b0;
                  alu.done_o         <= 1'b1;
                  state              <= DONE;
               end
            end
            DONE: begin
               alu.done_o <= 1'b0;
               alu.busy_o <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               alu.done_o <= 1'b0;
               alu.busy_o <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
